// File: rtl/uart_pkg.sv
// Shared definitions for the UART register blocks: status bit positions,
// register-select encodings and the status byte layout.
package uart_pkg;

    localparam int STAT_AVAIL_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVR_BIT   = 2;
    localparam int STAT_FERR_BIT  = 3;
    localparam int STAT_LVL_LSB   = 8;

    // Also decoded by the write-side demux; keep both sides in sync.
    localparam logic REG_SEL_CTRL = 1'b0;
    localparam logic REG_SEL_DATA = 1'b1;

    // Field order matches the STAT_*_BIT positions (MSB first).
    typedef struct packed {
        logic [3:0] rsvd;
        logic       frame_err;
        logic       overrun;
        logic       full;
        logic       rx_avail;
    } uart_status_t;

    function automatic uart_status_t make_status(input logic avail,
                                                 input logic full,
                                                 input logic ovr,
                                                 input logic ferr);
        uart_status_t s;
        s           = '0;
        s.rx_avail  = avail;
        s.full      = full;
        s.overrun   = ovr;
        s.frame_err = ferr;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous RX byte FIFO. A push while full is accepted only when a pop
// frees the head slot in the same cycle; otherwise it is ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = mem[rd_ptr];

    // Storage has no reset: entries are only visible once count covers them.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rd_regs.sv
// UART read-side register block: buffers received bytes, keeps sticky error
// flags and returns status or data on a host read one cycle later.
module uart_rd_regs
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32,
    parameter int BYTE_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rd_i,
    input  logic              reg_sel_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              rx_valid_i,
    input  logic [BYTE_W-1:0] rx_data_i,
    input  logic              rx_err_i,
    output logic              irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [BYTE_W-1:0] head;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              stat_rd;
    logic              data_rd;
    logic              ovr_set;
    logic              ferr_set;
    logic              overrun;
    logic              frame_err;
    uart_status_t      status;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] data_word;

    assign stat_rd  = rd_i && (reg_sel_i == REG_SEL_CTRL);
    assign data_rd  = rd_i && (reg_sel_i == REG_SEL_DATA);
    assign pop      = data_rd && !empty;
    assign push     = rx_valid_i && !rx_err_i;
    assign ferr_set = rx_valid_i && rx_err_i;
    // A concurrent pop makes room, so only a push into a still-full FIFO overruns.
    assign ovr_set  = push && full && !pop;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .push      (push),
        .push_data (rx_data_i),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign status = make_status(!empty, full, overrun, frame_err);

    always_comb begin
        status_word                        = '0;
        status_word[7:0]                   = status;
        status_word[STAT_LVL_LSB +: CW]    = count;
    end

    // No bypass: a read on an empty FIFO returns zero even if a byte arrives now.
    always_comb begin
        data_word = '0;
        if (!empty) begin
            data_word[BYTE_W-1:0] = head;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_i;
            if (stat_rd) begin
                rd_data_o <= status_word;
            end else if (data_rd) begin
                rd_data_o <= data_word;
            end
        end
    end

    // Set wins over the read-clear so an event in the read cycle is not lost.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (overrun   && !stat_rd) || ovr_set;
            frame_err <= (frame_err && !stat_rd) || ferr_set;
        end
    end

    assign irq_o = !empty || overrun || frame_err;

endmodule

// File: tb/tb_uart_rd_regs.sv
// Self-checking bench for uart_rd_regs: table of per-cycle steps with a
// read-response scoreboard, plus a hand-written reset-during-read sequence.
module tb_uart_rd_regs;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        rd_i;
    logic        reg_sel_i;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_err_i;
    logic        irq_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          push;
        bit          err;
        logic [7:0]  data;
        bit          rd;
        bit          sel;
        logic [31:0] exp_data;
        bit          exp_irq;
    } step_t;

    typedef struct {
        logic [31:0] d;
        int          idx;
    } exp_t;

    step_t steps[$];
    exp_t  exp_q[$];

    uart_rd_regs #(
        .FIFO_DEPTH (4),
        .DATA_W     (32),
        .BYTE_W     (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .rd_i       (rd_i),
        .reg_sel_i  (reg_sel_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .rx_err_i   (rx_err_i),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic step_t st(bit p, bit e, logic [7:0] d, bit r, bit s,
                                 logic [31:0] x, bit i);
        step_t t;
        t.push = p; t.err = e; t.data = d; t.rd = r; t.sel = s;
        t.exp_data = x; t.exp_irq = i;
        return t;
    endfunction

    // Response monitor: every rd_valid pulse must match the oldest outstanding read.
    always @(negedge clk_i) begin
        if (rd_valid_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1 data=0x%08h, expected no response", rd_data_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("rd_data_step%0d", e.idx), rd_data_o, e.d);
            end
        end
    end

    task automatic run_step(input step_t s, input int idx);
        @(negedge clk_i);
        rx_valid_i = s.push;
        rx_err_i   = s.err;
        rx_data_i  = s.data;
        rd_i       = s.rd;
        reg_sel_i  = s.sel;
        if (s.rd) begin
            exp_t e;
            e.d   = s.exp_data;
            e.idx = idx;
            exp_q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        check($sformatf("irq_step%0d", idx), {31'b0, irq_o}, {31'b0, s.exp_irq});
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(posedge clk_i);
            w++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        rst_n_i    = 1'b0;
        rd_i       = 1'b0;
        reg_sel_i  = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        rx_err_i   = 1'b0;

        //           push err data  rd sel exp_data      irq
        // 1: status after reset
        steps.push_back(st(0, 0, 8'h00, 1, 0, 32'h0000_0000, 0));
        // 2: two bytes in, two data reads, status
        steps.push_back(st(1, 0, 8'h41, 0, 0, 32'h0,         1));
        steps.push_back(st(1, 0, 8'h42, 0, 0, 32'h0,         1));
        steps.push_back(st(0, 0, 8'h00, 1, 1, 32'h0000_0041, 1));
        steps.push_back(st(0, 0, 8'h00, 1, 1, 32'h0000_0042, 0));
        steps.push_back(st(0, 0, 8'h00, 1, 0, 32'h0000_0000, 0));
        // 3: five pushes into a 4-deep FIFO
        steps.push_back(st(1, 0, 8'h10, 0, 0, 32'h0,         1));
        steps.push_back(st(1, 0, 8'h11, 0, 0, 32'h0,         1));
        steps.push_back(st(1, 0, 8'h12, 0, 0, 32'h0,         1));
        steps.push_back(st(1, 0, 8'h13, 0, 0, 32'h0,         1));
        steps.push_back(st(1, 0, 8'h14, 0, 0, 32'h0,         1));
        steps.push_back(st(0, 0, 8'h00, 1, 0, 32'h0000_0407, 1));
        steps.push_back(st(0, 0, 8'h00, 1, 0, 32'h0000_0403, 1));
        // 4: push while full with a concurrent pop
        steps.push_back(st(1, 0, 8'h55, 1, 1, 32'h0000_0010, 1));
        steps.push_back(st(0, 0, 8'h00, 1, 0, 32'h0000_0403, 1));
        // reg_sel toggling without rd must not produce a response
        steps.push_back(st(0, 0, 8'h00, 0, 1, 32'h0,         1));
        steps.push_back(st(0, 0, 8'h00, 1, 1, 32'h0000_0011, 1));
        steps.push_back(st(0, 0, 8'h00, 1, 1, 32'h0000_0012, 1));
        steps.push_back(st(0, 0, 8'h00, 1, 1, 32'h0000_0013, 1));
        steps.push_back(st(0, 0, 8'h00, 1, 1, 32'h0000_0055, 0));
        steps.push_back(st(0, 0, 8'h00, 1, 1, 32'h0000_0000, 0));
        steps.push_back(st(0, 0, 8'h00, 1, 0, 32'h0000_0000, 0));
        // 5: framing error handling
        steps.push_back(st(1, 1, 8'hAA, 0, 0, 32'h0,         1));
        steps.push_back(st(0, 0, 8'h00, 1, 0, 32'h0000_0008, 0));
        steps.push_back(st(0, 0, 8'h00, 1, 0, 32'h0000_0000, 0));
        steps.push_back(st(1, 1, 8'hAA, 1, 0, 32'h0000_0000, 1));
        steps.push_back(st(0, 0, 8'h00, 1, 0, 32'h0000_0008, 0));
        // 6: push and data read on an empty FIFO (no bypass)
        steps.push_back(st(1, 0, 8'h77, 1, 1, 32'h0000_0000, 1));
        steps.push_back(st(0, 0, 8'h00, 1, 0, 32'h0000_0101, 1));
        steps.push_back(st(0, 0, 8'h00, 0, 0, 32'h0,         1));

        repeat (2) @(posedge clk_i);
        #1;
        check("reset_rd_data",  rd_data_o, 32'h0);
        check("reset_rd_valid", {31'b0, rd_valid_o}, 32'h0);
        check("reset_irq",      {31'b0, irq_o}, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < steps.size(); i++) begin
            run_step(steps[i], i);
        end
        drain("drain_table");

        // Reset lands while a read is pending: no response may follow.
        @(negedge clk_i);
        rd_i      = 1'b1;
        reg_sel_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1 rd_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("midrd_rd_valid", {31'b0, rd_valid_o}, 32'h0);
        check("midrd_rd_data",  rd_data_o, 32'h0);
        check("midrd_irq",      {31'b0, irq_o}, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        run_step(st(0, 0, 8'h00, 1, 0, 32'h0000_0000, 0), 100);
        run_step(st(0, 0, 8'h00, 1, 1, 32'h0000_0000, 0), 101);
        run_step(st(0, 0, 8'h00, 0, 0, 32'h0,         0), 102);
        drain("drain_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
